// File: rtl/excep_issue_pkg.sv
// rtl/excep_issue_pkg.sv - exception bit indices, size codes, state encoding and alignment check
package excep_issue_pkg;

  localparam int EXC_ADEL_FETCH = 31;
  localparam int EXC_RI         = 30;
  localparam int EXC_OV         = 29;
  localparam int EXC_BP         = 28;
  localparam int EXC_SYS        = 27;
  localparam int EXC_ADEL_DATA  = 26;
  localparam int EXC_ADES       = 25;
  localparam int EXC_ERET       = 0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Returns {load fault, store fault}; byte accesses never fault, size 11 behaves as word.
  function automatic logic [1:0] align_fault(input logic       is_load,
                                             input logic       is_store,
                                             input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SIZE_HALF) mis = addr_lo[0];
    else if (size != SIZE_BYTE) mis = (addr_lo != 2'b00);
    return {is_load & mis, is_store & mis};
  endfunction

endpackage

// File: rtl/excep_issue.sv
// rtl/excep_issue.sv - MEM-stage exception initiator: raise to cp0, freeze, flush and redirect
module excep_issue
  import excep_issue_pkg::*;
#(
  parameter int WAIT_MAX = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid_i,
  input  logic [31:0]      mem_pc_i,
  input  logic             mem_in_delayslot_i,
  input  logic [31:0]      mem_excep_i,
  input  logic             mem_is_load_i,
  input  logic             mem_is_store_i,
  input  logic [1:0]       mem_size_i,
  input  logic [31:0]      mem_addr_i,
  input  logic             cp0_flush_i,
  input  logic [31:0]      cp0_return_pc_i,
  output logic [31:0]      exception_type_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      exception_addr_o,
  output logic             now_in_delayslot_o,
  output logic             mem_kill_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             excep_lost_o,
  output logic [CNT_W-1:0] excep_count_o
);

  localparam int WAIT_W = $clog2(WAIT_MAX) + 1;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               lost_q, lost_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [1:0]         align;
  logic [31:0]        exc_type;
  logic               has_exc;

  // Merge alignment faults into the upstream flags; a fetch fault masks any data-side fault.
  always_comb begin
    align    = align_fault(mem_is_load_i, mem_is_store_i, mem_size_i, mem_addr_i[1:0]);
    exc_type = mem_excep_i;
    if (mem_valid_i && !mem_excep_i[EXC_ADEL_FETCH]) begin
      exc_type[EXC_ADEL_DATA] = mem_excep_i[EXC_ADEL_DATA] | align[1];
      exc_type[EXC_ADES]      = mem_excep_i[EXC_ADES] | align[0];
    end
    has_exc = mem_valid_i && (exc_type != 32'd0);
  end

  // Next-state and output decode; every output stays low while in reset.
  always_comb begin
    state_d            = state_q;
    wait_cnt_d         = wait_cnt_q;
    lost_d             = lost_q;
    count_d            = count_q;
    exception_type_o   = 32'd0;
    pc_o               = 32'd0;
    exception_addr_o   = 32'd0;
    now_in_delayslot_o = 1'b0;
    mem_kill_o         = 1'b0;
    stall_o            = 1'b0;
    flush_o            = 1'b0;
    redirect_valid_o   = 1'b0;
    redirect_pc_o      = 32'd0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (cp0_flush_i) begin
            // cp0-originated flush (interrupt/timer) takes priority over a MEM exception
            flush_o          = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = cp0_return_pc_i;
            mem_kill_o       = 1'b1;
          end else if (has_exc) begin
            exception_type_o   = exc_type;
            pc_o               = mem_pc_i;
            exception_addr_o   = exc_type[EXC_ADEL_FETCH] ? mem_pc_i : mem_addr_i;
            now_in_delayslot_o = mem_in_delayslot_i;
            mem_kill_o         = 1'b1;
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          stall_o    = 1'b1;
          mem_kill_o = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (cp0_flush_i) begin
            flush_o          = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = cp0_return_pc_i;
            state_d          = ST_IDLE;
          end else if (wait_cnt_q == WAIT_W'(WAIT_MAX - 1)) begin
            // cp0 never answered (nested exception with EXL set): record it and let the pipe run
            lost_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, wait counter, sticky lost flag and issued-exception counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      lost_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lost_q     <= lost_d;
      count_q    <= count_d;
    end
  end

  assign excep_lost_o  = lost_q;
  assign excep_count_o = count_q;

endmodule

// File: tb/tb_excep_issue.sv
// tb/tb_excep_issue.sv - scoreboard bench for excep_issue
module tb_excep_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_in_delayslot_i, mem_is_load_i, mem_is_store_i, cp0_flush_i;
  logic [31:0] mem_pc_i, mem_excep_i, mem_addr_i, cp0_return_pc_i;
  logic [1:0]  mem_size_i;
  logic [31:0] exception_type_o, pc_o, exception_addr_o, redirect_pc_o;
  logic        now_in_delayslot_o, mem_kill_o, stall_o, flush_o, redirect_valid_o, excep_lost_o;
  logic [15:0] excep_count_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] typ, pc, addr, rpc;
    logic        ds, kill, stall, flush, rv, lost;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  excep_issue #(.WAIT_MAX(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
    .mem_excep_i(mem_excep_i), .mem_is_load_i(mem_is_load_i), .mem_is_store_i(mem_is_store_i),
    .mem_size_i(mem_size_i), .mem_addr_i(mem_addr_i),
    .cp0_flush_i(cp0_flush_i), .cp0_return_pc_i(cp0_return_pc_i),
    .exception_type_o(exception_type_o), .pc_o(pc_o), .exception_addr_o(exception_addr_o),
    .now_in_delayslot_o(now_in_delayslot_o), .mem_kill_o(mem_kill_o), .stall_o(stall_o),
    .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .excep_lost_o(excep_lost_o), .excep_count_o(excep_count_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] typ, pc, addr, input logic ds, kill, stall,
                              flush, rv, input logic [31:0] rpc, input logic lost,
                              input logic [15:0] cnt);
    exp_t e;
    e.typ = typ; e.pc = pc; e.addr = addr; e.ds = ds; e.kill = kill; e.stall = stall;
    e.flush = flush; e.rv = rv; e.rpc = rpc; e.lost = lost; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t quiet(input logic lost, input logic [15:0] cnt);
    return mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, lost, cnt);
  endfunction

  function automatic exp_t waiting(input logic [15:0] cnt);
    return mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, cnt);
  endfunction

  function automatic exp_t flushing(input logic stall, input logic [31:0] rpc, input logic [15:0] cnt);
    return mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b1, stall, 1'b1, 1'b1, rpc, 1'b0, cnt);
  endfunction

  task automatic drive(input logic valid, input logic [31:0] pc, input logic ds,
                       input logic [31:0] excep, input logic ld, st, input logic [1:0] size,
                       input logic [31:0] addr, input logic fl, input logic [31:0] rpc);
    mem_valid_i = valid; mem_pc_i = pc; mem_in_delayslot_i = ds; mem_excep_i = excep;
    mem_is_load_i = ld; mem_is_store_i = st; mem_size_i = size; mem_addr_i = addr;
    cp0_flush_i = fl; cp0_return_pc_i = rpc;
  endtask

  task automatic idle_in();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic cp0_flush(input logic [31:0] rpc);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 1'b1, rpc);
  endtask

  // Queue the expectation, sample on the falling edge, then move past the next rising edge.
  task automatic step(input exp_t e);
    exp_t g;
    sb_q.push_back(e);
    #4;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb_q.pop_front();
      check_val("type",  exception_type_o,   g.typ);
      check_val("pc",    pc_o,               g.pc);
      check_val("addr",  exception_addr_o,   g.addr);
      check_val("ds",    {31'd0, now_in_delayslot_o}, {31'd0, g.ds});
      check_val("kill",  {31'd0, mem_kill_o},         {31'd0, g.kill});
      check_val("stall", {31'd0, stall_o},            {31'd0, g.stall});
      check_val("flush", {31'd0, flush_o},            {31'd0, g.flush});
      check_val("rv",    {31'd0, redirect_valid_o},   {31'd0, g.rv});
      check_val("rpc",   redirect_pc_o,      g.rpc);
      check_val("lost",  {31'd0, excep_lost_o},       {31'd0, g.lost});
      check_val("count", {16'd0, excep_count_o},      {16'd0, g.cnt});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    @(posedge clk);
    #1;
    step(quiet(1'b0, 16'd0));
    rst = 1'b0;

    // lw misaligned, cp0 flush follows one cycle later
    drive(1'b1, 32'hbfc0_1000, 1'b0, 32'd0, 1'b1, 1'b0, 2'b10, 32'h8000_0002, 1'b0, 32'd0);
    step(mk(32'h0400_0000, 32'hbfc0_1000, 32'h8000_0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0));
    cp0_flush(32'hbfc0_0380);
    step(flushing(1'b1, 32'hbfc0_0380, 16'd1));
    idle_in();
    step(quiet(1'b0, 16'd1));

    // sh misaligned -> AdES
    drive(1'b1, 32'h0000_0100, 1'b0, 32'd0, 1'b0, 1'b1, 2'b01, 32'h0000_1001, 1'b0, 32'd0);
    step(mk(32'h0200_0000, 32'h0000_0100, 32'h0000_1001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd1));
    cp0_flush(32'hbfc0_0380);
    step(flushing(1'b1, 32'hbfc0_0380, 16'd2));
    // sb at odd address and aligned lw are transparent
    drive(1'b1, 32'h0000_0104, 1'b0, 32'd0, 1'b0, 1'b1, 2'b00, 32'h0000_1003, 1'b0, 32'd0);
    step(quiet(1'b0, 16'd2));
    drive(1'b1, 32'h0000_0108, 1'b0, 32'd0, 1'b1, 1'b0, 2'b10, 32'h0000_1004, 1'b0, 32'd0);
    step(quiet(1'b0, 16'd2));

    // fetch AdEL masks the data-side fault; BadVAddr is the PC
    drive(1'b1, 32'h0000_0203, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 2'b10, 32'h0000_0003, 1'b0, 32'd0);
    step(mk(32'h8000_0000, 32'h0000_0203, 32'h0000_0203, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd2));
    cp0_flush(32'hbfc0_0380);
    step(flushing(1'b1, 32'hbfc0_0380, 16'd3));

    // syscall in a delay slot; stall holds for two cycles before cp0 flushes
    drive(1'b1, 32'h0000_0300, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0, 32'd0);
    step(mk(32'h0800_0000, 32'h0000_0300, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd3));
    idle_in();
    step(waiting(16'd4));
    step(waiting(16'd4));
    cp0_flush(32'hbfc0_0380);
    step(flushing(1'b1, 32'hbfc0_0380, 16'd4));

    // interrupt flush in IDLE wins over an RI in MEM
    drive(1'b1, 32'h0000_0400, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b1, 32'hbfc0_0380);
    step(flushing(1'b0, 32'hbfc0_0380, 16'd4));
    idle_in();
    step(quiet(1'b0, 16'd4));

    // no cp0 answer: four cycles in WAIT then lost
    drive(1'b1, 32'h0000_0500, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0, 32'd0);
    step(mk(32'h1000_0000, 32'h0000_0500, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd4));
    idle_in();
    for (int i = 0; i < 4; i++) step(waiting(16'd5));
    step(quiet(1'b1, 16'd5));
    rst = 1'b1;
    step(quiet(1'b1, 16'd5));
    rst = 1'b0;
    step(quiet(1'b0, 16'd0));

    // reset while in WAIT: back to IDLE with no flush
    drive(1'b1, 32'h0000_0600, 1'b0, 32'h2000_0000, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 1'b0, 32'd0);
    step(mk(32'h2000_0000, 32'h0000_0600, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0));
    idle_in();
    rst = 1'b1;
    step(quiet(1'b0, 16'd1));
    rst = 1'b0;
    step(quiet(1'b0, 16'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
